// File: rtl/ysyx_24100006_pkg.sv
// Shared fetch/decode definitions: the NOP bubble word and the IF->ID entry layout.
package ysyx_24100006_pkg;

    // addi x0, x0, 0 -- shown to decode whenever no instruction is queued
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // One fetched instruction as it travels from IFU to IDU
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } if_entry_t;

endpackage

// File: rtl/ysyx_24100006_ifid_fifo.sv
// IF->ID instruction queue: a small circular buffer that decouples fetch
// latency from decode stalls and is emptied in one cycle on a redirect.
//
// Handshake: a beat transfers on the input side when in_valid & in_ready, and
// on the output side when out_valid & out_ready & ~stall_id. in_ready depends
// only on registered occupancy, so there is no combinational path from
// out_ready to in_ready. A flush cancels both transfers in its cycle.
module ysyx_24100006_ifid_fifo #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    input  logic                     in_fault,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     stall_id,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_fault,
    output logic [$clog2(DEPTH):0]   count
);
    import ysyx_24100006_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pointers wrap naturally because DEPTH is a power of two
    if_entry_t          mem_q [DEPTH];
    logic [AW-1:0]      wp_q, wp_d;
    logic [AW-1:0]      rp_q, rp_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               push, pop;
    if_entry_t          head;

    assign in_ready  = (cnt_q != CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~stall_id & ~flush;

    // Head entry; zeros and a NOP bubble when the queue is empty
    assign head      = mem_q[rp_q];
    assign out_pc    = out_valid ? head.pc    : 32'h0;
    assign out_inst  = out_valid ? head.inst  : NOP_INST;
    assign out_fault = out_valid ? head.fault : 1'b0;
    assign count     = cnt_q;

    // Next pointer/occupancy state; flush wins over any push or pop
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control registers; reset drops every queued entry immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= '{pc: in_pc, inst: in_inst, fault: in_fault};
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_ifid_fifo.sv
// Directed bench for the IF->ID instruction queue (DEPTH = 2).
module tb_ysyx_24100006_ifid_fifo;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_fault;
    logic        out_valid;
    logic        out_ready;
    logic        stall_id;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic [1:0]  count;

    int checks;
    int failures;

    ysyx_24100006_ifid_fifo #(.DEPTH(2), .NOP_INST(32'h0000_0013)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_fault  (in_fault),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stall_id  (stall_id),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_fault (out_fault),
        .count     (count)
    );

    // Clock: posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        in_fault = 1'b0; out_ready = 1'b0; stall_id = 1'b0;
        repeat (3) step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_inst !== 32'h0000_0013) begin failures++; $display("FAIL reset_out_inst got=%h exp=00000013", out_inst); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
        checks++; if (out_fault !== 1'b0) begin failures++; $display("FAIL reset_out_fault got=%0b exp=0", out_fault); end
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        reset = 1'b1;
    endtask

    task automatic test_push();
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0000_0297;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL push_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_pc !== 32'h8000_0000) begin failures++; $display("FAIL push_out_pc got=%h exp=80000000", out_pc); end
        checks++; if (out_inst !== 32'h0000_0297) begin failures++; $display("FAIL push_out_inst got=%h exp=00000297", out_inst); end
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL push_count got=%0d exp=1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL push_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0000_0001;
        step();
        in_pc = 32'h8000_0004; in_inst = 32'h0000_0002;
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL fill_count got=%0d exp=2", count); end
        // third beat must be held off while full
        in_pc = 32'h8000_0008; in_inst = 32'h0000_0003;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL fill_held_count got=%0d exp=2", count); end
        checks++; if (out_pc !== 32'h8000_0000) begin failures++; $display("FAIL fill_head0 got=%h exp=80000000", out_pc); end
        out_ready = 1'b1;
        step();
        checks++; if (out_pc !== 32'h8000_0004) begin failures++; $display("FAIL fill_head1 got=%h exp=80000004", out_pc); end
        checks++; if (out_inst !== 32'h0000_0002) begin failures++; $display("FAIL fill_inst1 got=%h exp=00000002", out_inst); end
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_drained got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] pc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = 32'h8000_0000 + 32'(4 * i);
            in_pc = pc; in_inst = 32'h1000_0000 + 32'(i);
            step();
            if (exp_q.size() != 0) exp_q.pop_front();
            exp_q.push_back(pc);
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_q[0]) begin failures++; $display("FAIL stream_head[%0d] got=%h/%0b exp=%h/1", i, out_pc, out_valid, exp_q[0]); end
            checks++; if (count !== 2'(exp_q.size())) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", i, count, exp_q.size()); end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL stream_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_pc = 32'h8000_0008; in_inst = 32'h0000_0008;
        step();
        out_ready = 1'b1; stall_id = 1'b1;
        in_pc = 32'h8000_000C; in_inst = 32'h0000_000C;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL stall_count got=%0d exp=2", count); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_pc !== 32'h8000_0008) begin failures++; $display("FAIL stall_head[%0d] got=%h exp=80000008", i, out_pc); end
        end
        stall_id = 1'b0;
        step();
        checks++; if (out_pc !== 32'h8000_000C || count !== 2'd1) begin failures++; $display("FAIL stall_pop1 got=%h/%0d exp=8000000c/1", out_pc, count); end
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL stall_pop2 got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0000_0011;
        step();
        in_pc = 32'h8000_0004;
        step();
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
        flush = 1'b1; in_pc = 32'h8000_0010;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_inst !== 32'h0000_0013) begin failures++; $display("FAIL flush_out_inst got=%h exp=00000013", out_inst); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        in_valid = 1'b1; in_pc = 32'h8000_0100; in_inst = 32'h0000_0100;
        step();
        in_valid = 1'b0;
        checks++; if (out_pc !== 32'h8000_0100 || count !== 2'd1) begin failures++; $display("FAIL flush_refetch got=%h/%0d exp=80000100/1", out_pc, count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_fault_async_reset();
        in_valid = 1'b1; in_pc = 32'h8000_0200; in_inst = 32'h0000_0200; in_fault = 1'b1;
        step();
        in_valid = 1'b0; in_fault = 1'b0;
        checks++; if (out_fault !== 1'b1) begin failures++; $display("FAIL fault_head got=%0b exp=1", out_fault); end
        // drop reset between edges; state must clear without a clock edge
        #3 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (count !== 2'd0 || out_fault !== 1'b0) begin failures++; $display("FAIL async_reset_state got=%0d/%0b exp=0/0", count, out_fault); end
        step();
        reset = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || out_inst !== 32'h0000_0013) begin failures++; $display("FAIL post_reset got=%0b/%h exp=1/00000013", in_ready, out_inst); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_push();
        test_fill();
        test_back_to_back();
        test_stall();
        test_flush();
        test_fault_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_ifid_fifo.md
# ysyx_24100006_ifid_fifo

Instruction queue between the fetch stage and the decode stage. Captures each fetched `{pc, inst, fault}` triple from the IFU's valid/ready handshake into a small circular buffer. Presents the oldest entry to the IDU. It decouples AXI fetch latency from decode stalls and discards all buffered instructions on a control-flow redirect.

## Interface
Parameters:
- `DEPTH`, 2: number of entries; power of two, at least 2.
- `NOP_INST`, 32'h0000_0013: value driven on `out_inst` while the queue is empty.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `flush` in 1: redirect from EXE; same cycle as IFU `redirect_valid`.
- `in_valid` in 1: IFU has a fetched instruction (IFU `if_in_valid`).
- `in_ready` out 1: queue can accept (to IFU `if_in_ready`).
- `in_pc` in 32: PC of the incoming instruction.
- `in_inst` in 32: incoming instruction word.
- `in_fault` in 1: instruction access fault flag for the incoming entry.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: IDU accepts.
- `stall_id` in 1: decode hazard stall; blocks the pop.
- `out_pc` out 32: head PC.
- `out_inst` out 32: head instruction.
- `out_fault` out 1: head fault flag.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: `DEPTH` entries of `{pc[31:0], inst[31:0], fault}`. Write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrap modulo DEPTH. Occupancy counter `cnt` runs 0..DEPTH.
- `push = in_valid & in_ready & ~flush`.
- `pop = out_valid & out_ready & ~stall_id & ~flush`.
- `in_ready = (cnt != DEPTH)`. It depends only on registered state and has no combinational path from `out_ready`.
- `out_valid = (cnt != 0)`.
- `out_pc` and `out_fault` show entry `rp`. `out_inst` shows entry `rp`, or `NOP_INST` when `cnt == 0`. `out_pc` and `out_fault` are 0 when `cnt == 0`.
- Push writes entry `wp` and advances `wp`. Pop advances `rp`.
- `cnt` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, including when full is not yet reached and when at DEPTH−1.
- Flush takes priority over everything. It sets `wp = rp = 0` and `cnt = 0`, and blocks any push or pop in that cycle, so the incoming beat is dropped. The IFU's epoch logic is responsible for refetching.
- Push and pop together when `cnt == 0` is impossible, because `out_valid` is 0. There is no bypass from input to output.
- Push and pop together when `cnt == DEPTH` is impossible, because `in_ready` is 0. The pop frees a slot for the next cycle.
- `stall_id` freezes the head without affecting pushes.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets: `wp = rp = cnt = 0`, `in_ready = 1`, `out_valid = 0`, `out_inst = NOP_INST`, `out_pc = 0`, `out_fault = 0`, `count = 0`.
- Storage is not reset.
- Reset asserted mid-operation discards all entries immediately.
- Latency: an entry pushed at edge N appears on `out_*` with `out_valid = 1` after edge N. The minimum input-to-output latency is 1 cycle.
- Throughput: 1 entry per cycle with `DEPTH >= 2` when push and pop are continuous.
- A flush sampled at edge N gives `out_valid = 0` and `in_ready = 1` after edge N.
- Handshake rules:
  - Outputs are stable while `out_valid & ~(out_ready & ~stall_id)`.
  - No entry is lost or duplicated across pointer wrap.

## Structure
- A shared package `ysyx_24100006_pkg` holds:
  - the `NOP_INST` constant;
  - the entry typedef `if_entry_t {pc, inst, fault}`, reused by the IDU.
- The block is a single module. The occupancy/pointer control is small enough to stay inline, so there is no sub-module.
- Storage is a register array. No SRAM macro is used.

## Test plan
- Reset then push: hold `reset = 0` for 3 cycles, then push pc=0x8000_0000, inst=0x0000_0297. After one edge, `out_valid = 1`, `out_pc = 0x8000_0000`, `out_inst = 0x0000_0297`, `count = 1`.
- Fill and backpressure: with `out_ready = 0`, push 0x8000_0000 and 0x8000_0004. `in_ready = 0` and `count = 2`. A third `in_valid` is held off. Raising `out_ready` pops in order 0x8000_0000 then 0x8000_0004.
- Streaming across wrap: with `out_ready = 1` continuously, push 8 sequential PCs 0x8000_0000..0x8000_001C. Each is output exactly once in order, one per cycle, and `count` never exceeds 1.
- Stall hold: with head 0x8000_0008 and `stall_id = 1` for 4 cycles, the head stays 0x8000_0008 and a concurrent push of 0x8000_000C raises `count` to 2. After `stall_id` drops, both pop in order.
- Flush with a simultaneous push, when `count = 2`: assert `flush` together with `in_valid` (pc 0x8000_0010). After the edge, `count = 0`, `out_valid = 0`, `out_inst = 0x0000_0013`. The next push of 0x8000_0100 appears as the head.
- Fault propagation and asynchronous reset: push with `in_fault = 1`, and `out_fault = 1` at the head. Dropping `reset` mid-cycle clears `out_valid` to 0 immediately, without waiting for a clock edge.
